// File: rtl/beat_stream_tx_pkg.sv
// Shared constants for the beat_stream_tx burst transmitter: default sizes,
// FSM state encoding and skid FIFO depth.
package beat_stream_pkg;

   localparam int DATA_W_DEF = 32;
   localparam int BEATS_DEF  = 32;
   localparam int CNT_W_DEF  = $clog2(BEATS_DEF);
   localparam int LAST_IDX   = BEATS_DEF - 1;

   localparam int FIFO_DEPTH = 2;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

endpackage

// File: rtl/beat_stream_tx_if.sv
// Valid/ready beat stream between the transmitter (master) and the
// downstream receiver (slave).
interface beat_stream_tx_if
   import beat_stream_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF
);

   logic              m_valid;
   logic              m_ready;
   logic [DATA_W-1:0] m_data;
   logic              m_last;

   modport master (
      output m_valid,
      output m_data,
      output m_last,
      input  m_ready
   );

   modport slave (
      input  m_valid,
      input  m_data,
      input  m_last,
      output m_ready
   );

endinterface

// File: rtl/beat_stream_tx_fifo.sv
// tx_skid_fifo: 2-entry FIFO holding buffer words between read return and
// beat handshake. Push while full is accepted only together with a pop.
module tx_skid_fifo
   import beat_stream_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              push,
   input  logic [DATA_W-1:0] din,
   input  logic              pop,
   output logic [DATA_W-1:0] dout,
   output logic              empty,
   output logic              full,
   output logic [1:0]        count
);

   logic [DATA_W-1:0] mem [FIFO_DEPTH];
   logic              wr_ptr;
   logic              rd_ptr;
   logic              do_push;
   logic              do_pop;

   assign empty   = (count == 2'd0);
   assign full    = (count == 2'(FIFO_DEPTH));
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem[i] <= '0;
         end
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else if (flush) begin
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= ~wr_ptr;
         end
         if (do_pop) begin
            rd_ptr <= ~rd_ptr;
         end
         count <= count + {1'b0, do_push} - {1'b0, do_pop};
      end
   end

endmodule

// File: rtl/beat_stream_tx.sv
// beat_stream_tx: reads a BEATS-word frame from a local buffer and sends it
// as one valid/ready burst. Build option BEAT_STREAM_TX_ABORT_EN adds abort.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | issuing buffer reads and presenting beats
// DONE  | one-cycle done pulse, start ignored
module beat_stream_tx
   import beat_stream_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int BEATS  = BEATS_DEF,
   parameter int CNT_W  = CNT_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic              mem_rd_en,
   output logic [CNT_W-1:0]  mem_rd_addr,
   input  logic [DATA_W-1:0] mem_rd_data,
   beat_stream_tx_if.master  tx,
   output logic [CNT_W-1:0]  beat_cnt
`ifdef BEAT_STREAM_TX_ABORT_EN
   ,
   input  logic              abort,
   output logic              aborted
`endif
);

   localparam logic [CNT_W-1:0] LAST      = CNT_W'(BEATS - 1);
   localparam logic [CNT_W:0]   ISSUE_END = (CNT_W + 1)'(BEATS);

   logic [1:0]        state;
   logic [CNT_W:0]    issue_cnt;
   logic              rd_pending;
   logic              in_run;
   logic              abort_req;
   logic              hs;
   logic              issue;
   logic [2:0]        occ_after;

   logic              fifo_push;
   logic              fifo_pop;
   logic              fifo_empty;
   logic              fifo_full;
   logic [1:0]        fifo_count;
   logic [DATA_W-1:0] fifo_dout;

   assign in_run = (state == RUN);
   assign busy   = in_run;
   assign done   = (state == DONE);

`ifdef BEAT_STREAM_TX_ABORT_EN
   assign abort_req = in_run && abort;
`else
   assign abort_req = 1'b0;
`endif

   // A word returning into an empty FIFO is presented in its arrival cycle,
   // so the first beat appears two cycles after start is sampled.
   assign tx.m_valid = !fifo_empty || rd_pending;
   assign tx.m_data  = !fifo_empty ? fifo_dout :
                       (rd_pending ? mem_rd_data : '0);
   assign tx.m_last  = (beat_cnt == LAST) && tx.m_valid;
   assign hs         = tx.m_valid && tx.m_ready;

   assign fifo_pop  = hs && !fifo_empty;
   assign fifo_push = rd_pending && !(fifo_empty && hs) && (!fifo_full || fifo_pop);

   // Words buffered or in flight once this cycle's handshake retires.
   assign occ_after = {1'b0, fifo_count} + {2'b00, rd_pending} - {2'b00, hs};

   assign issue       = in_run && !abort_req && (issue_cnt < ISSUE_END) &&
                        (occ_after < 3'(FIFO_DEPTH));
   assign mem_rd_en   = issue;
   assign mem_rd_addr = issue_cnt[CNT_W-1:0];

   tx_skid_fifo #(
      .DATA_W (DATA_W)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (abort_req),
      .push  (fifo_push),
      .din   (mem_rd_data),
      .pop   (fifo_pop),
      .dout  (fifo_dout),
      .empty (fifo_empty),
      .full  (fifo_full),
      .count (fifo_count)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         issue_cnt  <= '0;
         beat_cnt   <= '0;
         rd_pending <= 1'b0;
      end else begin
         rd_pending <= issue;
         case (state)
            IDLE: begin
               if (start) begin
                  state     <= RUN;
                  issue_cnt <= '0;
                  beat_cnt  <= '0;
               end
            end
            RUN: begin
               if (abort_req) begin
                  state     <= IDLE;
                  issue_cnt <= '0;
                  beat_cnt  <= '0;
               end else begin
                  if (issue) begin
                     issue_cnt <= issue_cnt + 1'b1;
                  end
                  if (hs) begin
                     if (beat_cnt == LAST) begin
                        state <= DONE;
                     end else begin
                        beat_cnt <= beat_cnt + 1'b1;
                     end
                  end
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

`ifdef BEAT_STREAM_TX_ABORT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         aborted <= 1'b0;
      end else begin
         aborted <= abort_req;
      end
   end
`endif

endmodule

// File: tb/tb_beat_stream_tx.sv
// Directed bench for beat_stream_tx: burst timing, backpressure, ignored
// starts, mid-burst reset and (with BEAT_STREAM_TX_ABORT_EN) abort.
module tb_beat_stream_tx;
   import beat_stream_pkg::*;

   localparam int DW = 32;
   localparam int NB = 32;
   localparam int CW = 5;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic          busy;
   logic          done;
   logic          mem_rd_en;
   logic [CW-1:0] mem_rd_addr;
   logic [DW-1:0] mem_rd_data;
   logic [CW-1:0] beat_cnt;
`ifdef BEAT_STREAM_TX_ABORT_EN
   logic          abort = 1'b0;
   logic          aborted;
`endif

   int n_cmp = 0;
   int n_err = 0;

   logic [DW-1:0] buffer [NB];

   beat_stream_tx_if #(.DATA_W(DW)) bus ();

   beat_stream_tx #(
      .DATA_W (DW),
      .BEATS  (NB),
      .CNT_W  (CW)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .busy        (busy),
      .done        (done),
      .mem_rd_en   (mem_rd_en),
      .mem_rd_addr (mem_rd_addr),
      .mem_rd_data (mem_rd_data),
      .tx          (bus),
      .beat_cnt    (beat_cnt)
`ifdef BEAT_STREAM_TX_ABORT_EN
      ,
      .abort       (abort),
      .aborted     (aborted)
`endif
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_rd_en) mem_rd_data <= buffer[mem_rd_addr];
   end

   task automatic chk_b(input string tag, input logic obs, input logic exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic chk_w(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset(input string tag);
      chk_b({tag, "_busy"}, busy, 1'b0);
      chk_b({tag, "_done"}, done, 1'b0);
      chk_b({tag, "_rd_en"}, mem_rd_en, 1'b0);
      chk_w({tag, "_rd_addr"}, 32'(mem_rd_addr), 32'd0);
      chk_b({tag, "_valid"}, bus.m_valid, 1'b0);
      chk_w({tag, "_data"}, bus.m_data, 32'd0);
      chk_b({tag, "_last"}, bus.m_last, 1'b0);
      chk_w({tag, "_beat_cnt"}, 32'(beat_cnt), 32'd0);
   endtask

   // Caller holds start=1 for the current cycle; pat 0 = always ready,
   // pat 1 = ready 1,0,0,1 repeating. poke re-pulses start at beats 5, 31 and on done.
   task automatic run_to_done(input string tag, input int pat, input bit poke, input int issued0);
      int            exp_i = 0;
      int            hs_n = 0;
      int            issued = issued0;
      int            max_out = issued0;
      int            done_n = 0;
      int            cyc = 0;
      bit            prev_stall = 1'b0;
      logic [DW-1:0] prev_data = '0;
      while (done_n == 0 && cyc < 400) begin
         @(negedge clk);
         start = poke && (exp_i == 5 || exp_i == NB - 1);
         bus.m_ready = (pat == 0) || (cyc % 4 == 0) || (cyc % 4 == 3);
         #1;
         if (mem_rd_en) issued++;
         if (prev_stall) begin
            chk_b({tag, "_hold_valid"}, bus.m_valid, 1'b1);
            chk_w({tag, "_hold_data"}, bus.m_data, prev_data);
         end
         if (bus.m_valid) begin
            chk_w({tag, "_data"}, bus.m_data, 32'hA000 + 32'(exp_i));
            chk_b({tag, "_last"}, bus.m_last, exp_i == NB - 1);
         end else begin
            chk_b({tag, "_last_idle"}, bus.m_last, 1'b0);
         end
         prev_stall = bus.m_valid && !bus.m_ready;
         prev_data  = bus.m_data;
         if (bus.m_valid && bus.m_ready) begin
            hs_n++;
            exp_i++;
         end
         if (issued - hs_n > max_out) max_out = issued - hs_n;
         if (done) begin
            done_n++;
            if (poke) start = 1'b1;
         end
         cyc++;
      end
      chk_b({tag, "_done_seen"}, done_n == 1, 1'b1);
      chk_w({tag, "_handshakes"}, 32'(hs_n), 32'(NB));
      chk_b({tag, "_outstanding_le2"}, max_out <= 2, 1'b1);
      chk_w({tag, "_beat_cnt_sat"}, 32'(beat_cnt), 32'(NB - 1));
      @(negedge clk);
      start = 1'b0;
      #1;
      chk_b({tag, "_done_one_cycle"}, done, 1'b0);
      chk_b({tag, "_idle_busy"}, busy, 1'b0);
      chk_b({tag, "_idle_rd_en"}, mem_rd_en, 1'b0);
      @(negedge clk);
      #1;
      chk_b({tag, "_idle2_busy"}, busy, 1'b0);
      chk_b({tag, "_idle2_done"}, done, 1'b0);
   endtask

   initial begin
      int n_rd;
      int k;
      for (int i = 0; i < NB; i++) buffer[i] = 32'hA000 + 32'(i);
      mem_rd_data = '0;
      bus.m_ready = 1'b0;

      repeat (3) @(negedge clk);
      #1;
      chk_reset("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // continuous ready: exact latency, one beat per cycle
      @(negedge clk);
      start = 1'b1;
      bus.m_ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      #1;
      chk_b("t1_first_rd_en", mem_rd_en, 1'b1);
      chk_w("t1_first_rd_addr", 32'(mem_rd_addr), 32'd0);
      chk_b("t1_no_valid_yet", bus.m_valid, 1'b0);
      chk_b("t1_busy", busy, 1'b1);
      for (int i = 0; i < NB; i++) begin
         @(negedge clk);
         #1;
         chk_b("t1_valid", bus.m_valid, 1'b1);
         chk_w("t1_data", bus.m_data, 32'hA000 + 32'(i));
         chk_b("t1_last", bus.m_last, i == NB - 1);
         chk_b("t1_no_done", done, 1'b0);
      end
      @(negedge clk);
      #1;
      chk_b("t1_done", done, 1'b1);
      chk_b("t1_done_valid", bus.m_valid, 1'b0);
      chk_b("t1_done_busy", busy, 1'b0);
      @(negedge clk);
      #1;
      chk_b("t1_done_pulse", done, 1'b0);

      // backpressure 1,0,0,1
      @(negedge clk);
      start = 1'b1;
      run_to_done("t2", 1, 1'b0, 0);

      // ready low from start for 20 cycles
      @(negedge clk);
      start = 1'b1;
      bus.m_ready = 1'b0;
      n_rd = 0;
      repeat (20) begin
         @(negedge clk);
         start = 1'b0;
         #1;
         if (mem_rd_en) n_rd++;
      end
      chk_w("t3_reads_stalled", 32'(n_rd), 32'd2);
      chk_b("t3_valid_held", bus.m_valid, 1'b1);
      chk_w("t3_data_held", bus.m_data, 32'hA000);
      chk_w("t3_beat_cnt", 32'(beat_cnt), 32'd0);
      run_to_done("t3", 0, 1'b0, 2);

      // start pulsed at beats 5, 31 and on the done cycle
      @(negedge clk);
      start = 1'b1;
      run_to_done("t4", 0, 1'b1, 0);

      // reset mid-burst
      @(negedge clk);
      start = 1'b1;
      bus.m_ready = 1'b1;
      k = 0;
      while (k < 60) begin
         @(negedge clk);
         start = 1'b0;
         #1;
         if (beat_cnt == 5'd10) break;
         k++;
      end
      chk_w("t5_reached_beat10", 32'(beat_cnt), 32'd10);
      rst_n = 1'b0;
      #1;
      chk_reset("t5_rst");
      @(negedge clk);
      #1;
      chk_b("t5_rst_no_done", done, 1'b0);
      rst_n = 1'b1;
      @(negedge clk);
      start = 1'b1;
      run_to_done("t5", 0, 1'b0, 0);

`ifdef BEAT_STREAM_TX_ABORT_EN
      // abort at beat 12 with a same-cycle handshake
      @(negedge clk);
      start = 1'b1;
      bus.m_ready = 1'b1;
      k = 0;
      while (k < 60) begin
         @(negedge clk);
         start = 1'b0;
         #1;
         if (beat_cnt == 5'd12) break;
         k++;
      end
      chk_w("t6_reached_beat12", 32'(beat_cnt), 32'd12);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      #1;
      chk_b("t6_valid_dropped", bus.m_valid, 1'b0);
      chk_b("t6_aborted", aborted, 1'b1);
      chk_b("t6_no_done", done, 1'b0);
      chk_b("t6_busy", busy, 1'b0);
      chk_w("t6_beat_cnt_clr", 32'(beat_cnt), 32'd0);
      @(negedge clk);
      #1;
      chk_b("t6_aborted_pulse", aborted, 1'b0);
      chk_b("t6_no_done2", done, 1'b0);
      chk_b("t6_valid_idle", bus.m_valid, 1'b0);
      @(negedge clk);
      start = 1'b1;
      run_to_done("t6", 0, 1'b0, 0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
